cache_axi_arbiter: RTL

- Shares the single cache-side AXIMaster (burst master, isCache=1) between three line-level requesters:
  - D-cache writeback (LineWriteBuffer)
  - D-cache linefill (LinefillBuffer)
  - I-cache linefill (future I-cache refill path replacing the ROM)
- Sequences one transaction at a time: grants a requester, issues the start pulse, routes read beats back, and reports completion.
- Sits between the buffers and the CAXI master in soc.

---
 rtl/cache_axi_arbiter_pkg.sv | 34 +++
 rtl/cache_axi_arbiter_rr_pick2.sv | 25 ++
 rtl/cache_axi_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared definitions for the cache-side AXI arbiter.
//   - arb_state_e : arbiter sequencing states
//   - GNT_*       : bit positions of the one-hot grant vector
//   - rr_sel_e    : round-robin selection between the D and I linefill paths
//   - LINE_W / WORD_W / LINE_WORDS : cache line geometry defaults
package cache_axi_arbiter_pkg;

  localparam int unsigned LINE_W     = 256;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_WORDS = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RELEASE
  } arb_state_e;

  localparam int unsigned GNT_WB = 0;
  localparam int unsigned GNT_DL = 1;
  localparam int unsigned GNT_IL = 2;
  localparam int unsigned GNT_N  = 3;

  typedef enum logic {
    RR_D = 1'b0,
    RR_I = 1'b1
  } rr_sel_e;

  function automatic logic [GNT_N-1:0] gnt_onehot(input int unsigned idx);
    gnt_onehot      = '0;
    gnt_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/cache_axi_arbiter_rr_pick2.sv
// Two-way round-robin picker between the D-cache and I-cache linefill paths.
//   req_d, req_i : pending linefill requests
//   last         : path that won the previous fill
//   pick         : winner; a lone requester always wins, a tie goes to the
//                  path that did not win last time
module rr_pick2
  import cache_axi_arbiter_pkg::*;
(
  input  logic    req_d,
  input  logic    req_i,
  input  rr_sel_e last,
  output rr_sel_e pick
);

  always_comb begin
    pick = RR_D;
    if (req_d && req_i) begin
      if (last == RR_D) pick = RR_I;
      else              pick = RR_D;
    end else if (req_i) begin
      pick = RR_I;
    end
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares the cache-side AXI burst master between three line-level requesters:
// D-cache writeback (WB), D-cache linefill (DL) and I-cache linefill (IL).
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
//   Clk, Rst              : clock, asynchronous active-low reset
//   WB_* / DL_* / IL_*    : requester handshakes (Req level in, Gnt/Done out,
//                           WordValid per filler)
//   RData                 : read beat broadcast to all requesters
//   M_*                   : start pulses, latched addresses/data and completion
//                           inputs of the AXI master
//   Err                   : sticky error (short read burst or WAIT watchdog)
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = cache_axi_arbiter_pkg::LINE_W,
  parameter int unsigned WORD_W     = cache_axi_arbiter_pkg::WORD_W,
  parameter int unsigned LINE_WORDS = cache_axi_arbiter_pkg::LINE_WORDS,
  parameter int unsigned TIMEOUT    = 1024
)(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              WB_Req,
  input  logic [ADDR_W-1:0] WB_Addr,
  input  logic [LINE_W-1:0] WB_Data,
  output logic              WB_Gnt,
  output logic              WB_Done,
  input  logic              DL_Req,
  input  logic [ADDR_W-1:0] DL_Addr,
  output logic              DL_Gnt,
  output logic              DL_WordValid,
  output logic              DL_Done,
  input  logic              IL_Req,
  input  logic [ADDR_W-1:0] IL_Addr,
  output logic              IL_Gnt,
  output logic              IL_WordValid,
  output logic              IL_Done,
  output logic [WORD_W-1:0] RData,
  output logic              M_StartRead,
  output logic              M_StartWrite,
  output logic [ADDR_W-1:0] M_RAddr,
  output logic [ADDR_W-1:0] M_WAddr,
  output logic [LINE_W-1:0] M_WData,
  input  logic [WORD_W-1:0] M_RData,
  input  logic              M_RValid,
  input  logic              M_ReadCompleted,
  input  logic              M_WriteCompleted,
  output logic              Err
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS + 1);
  localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(LINE_WORDS);

  arb_state_e        state, state_nxt;
  logic [GNT_N-1:0]  gnt;
  rr_sel_e           rr_last, rr_pick;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic              is_fill, in_wait, any_req, done_match;

  rr_pick2 u_rr_pick2 (
    .req_d (DL_Req),
    .req_i (IL_Req),
    .last  (rr_last),
    .pick  (rr_pick)
  );

  assign is_fill    = gnt[GNT_DL] | gnt[GNT_IL];
  assign in_wait    = (state == ARB_WAIT);
  assign any_req    = WB_Req | DL_Req | IL_Req;
  assign done_match = is_fill ? M_ReadCompleted : M_WriteCompleted;

  // Beat count including a beat arriving this cycle, so a beat coincident with
  // ReadCompleted still counts toward a full line.
  assign beat_nxt = (in_wait && is_fill && M_RValid && beat_cnt != BEAT_FULL)
                    ? beat_cnt + BEAT_W'(1) : beat_cnt;

  assign WB_Gnt       = gnt[GNT_WB];
  assign DL_Gnt       = gnt[GNT_DL];
  assign IL_Gnt       = gnt[GNT_IL];
  assign M_StartRead  = (state == ARB_ISSUE) && is_fill;
  assign M_StartWrite = (state == ARB_ISSUE) && gnt[GNT_WB];
  assign WB_Done      = (state == ARB_RELEASE) && gnt[GNT_WB];
  assign DL_Done      = (state == ARB_RELEASE) && gnt[GNT_DL];
  assign IL_Done      = (state == ARB_RELEASE) && gnt[GNT_IL];
  assign DL_WordValid = in_wait && gnt[GNT_DL] && M_RValid;
  assign IL_WordValid = in_wait && gnt[GNT_IL] && M_RValid;
  assign RData        = in_wait ? M_RData : '0;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:    if (any_req) state_nxt = ARB_ISSUE;
      ARB_ISSUE:   state_nxt = ARB_WAIT;
      ARB_WAIT:    if (done_match) state_nxt = ARB_RELEASE;
      ARB_RELEASE: state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      gnt      <= '0;
      rr_last  <= RR_D;
      M_RAddr  <= '0;
      M_WAddr  <= '0;
      M_WData  <= '0;
      beat_cnt <= '0;
      wd_cnt   <= '0;
      Err      <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (WB_Req) begin
            gnt     <= gnt_onehot(GNT_WB);
            M_WAddr <= WB_Addr;
            M_WData <= WB_Data;
          end else if (DL_Req || IL_Req) begin
            rr_last <= rr_pick;
            if (rr_pick == RR_I) begin
              gnt     <= gnt_onehot(GNT_IL);
              M_RAddr <= IL_Addr;
            end else begin
              gnt     <= gnt_onehot(GNT_DL);
              M_RAddr <= DL_Addr;
            end
          end
        end
        ARB_ISSUE: begin
          beat_cnt <= '0;
          wd_cnt   <= '0;
        end
        ARB_WAIT: begin
          beat_cnt <= beat_nxt;
          if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + WD_W'(1);
          if (TIMEOUT != 0 && wd_cnt == WD_LAST) Err <= 1'b1;
          if (is_fill && M_ReadCompleted && beat_nxt != BEAT_FULL) Err <= 1'b1;
        end
        ARB_RELEASE: gnt <= '0;
        default:     gnt <= '0;
      endcase
    end
  end

endmodule
